cnt_step_monitor: RTL and testbench

- Downstream observer of the 4-bit synchronous up/down counter (step 1/2, up/down).
- Samples the counter's 4-bit output every enabled cycle and classifies each transition as up1, up2, down1, down2 or illegal.
- Reports the decoded direction and step, wrap-around pulses and a saturating wrap count.
- Raises a sticky error on any illegal transition; used as a built-in checker and as the feed for the display and status logic.

---
 rtl/cnt_step_monitor.sv | 176 +++++++++++++++++
 tb/tb_cnt_step_monitor.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/cnt_step_monitor.sv
// Observer for a 4-bit up/down counter (step 1 or 2): decodes direction/step,
// flags wrap-arounds and illegal jumps. Optional error counter: CNT_STEP_MONITOR_ERRCNT_EN.
module cnt_step_monitor #(
  parameter int WRAP_W = 8,
  parameter int ERRC_W = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              clr,
  input  logic [3:0]        cnt,
  output logic              dir,
  output logic              step2,
  output logic              locked,
  output logic              mode_chg,
  output logic              wrap,
  output logic [WRAP_W-1:0] wraps,
  output logic              err
`ifdef CNT_STEP_MONITOR_ERRCNT_EN
  ,
  output logic [ERRC_W-1:0] err_cnt,
  output logic              err_p
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_PRIMED = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Returns {legal, dir, step2} for a 4-bit wrapping delta.
  function automatic logic [2:0] classify(input logic [3:0] d);
    logic [2:0] r;
    case (d)
      4'd1:    r = 3'b100;
      4'd2:    r = 3'b101;
      4'd15:   r = 3'b110;
      4'd14:   r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  state_t            state_r, state_nxt_s;
  logic [3:0]        prev_r, prev_nxt_s;
  logic              dir_r, dir_nxt_s;
  logic              step2_r, step2_nxt_s;
  logic              locked_r, locked_nxt_s;
  logic              mode_chg_r, mode_chg_nxt_s;
  logic              wrap_r, wrap_nxt_s;
  logic [WRAP_W-1:0] wraps_r, wraps_nxt_s;
  logic              err_r, err_nxt_s;

  logic [3:0]        delta_s;
  logic [2:0]        cls_s;
  logic              legal_s, ndir_s, nstep2_s;
  logic              wrap_det_s, sample_s, good_s, bad_s;

  // Transition decode against the previously sampled value.
  always_comb begin
    delta_s    = cnt - prev_r;
    cls_s      = classify(delta_s);
    legal_s    = cls_s[2];
    ndir_s     = cls_s[1];
    nstep2_s   = cls_s[0];
    // Crossing 15/0 shows up as the raw value moving against the direction.
    wrap_det_s = ndir_s ? (cnt > prev_r) : (cnt < prev_r);
    sample_s   = en && !clr && (state_r != ST_EMPTY);
    good_s     = sample_s && legal_s;
    bad_s      = sample_s && !legal_s;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    if (clr) begin
      if (state_r == ST_LOCKED) begin
        state_nxt_s = ST_PRIMED;
      end else begin
        state_nxt_s = state_r;
      end
    end else if (en) begin
      case (state_r)
        ST_EMPTY:  state_nxt_s = ST_PRIMED;
        ST_PRIMED: state_nxt_s = good_s ? ST_LOCKED : ST_PRIMED;
        ST_LOCKED: state_nxt_s = ST_LOCKED;
        default:   state_nxt_s = ST_EMPTY;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Next values for the decoded outputs, pulses and counters.
  always_comb begin
    prev_nxt_s     = en ? cnt : prev_r;
    dir_nxt_s      = good_s ? ndir_s : dir_r;
    step2_nxt_s    = good_s ? nstep2_s : step2_r;
    mode_chg_nxt_s = good_s && (state_r == ST_LOCKED) &&
                     ({ndir_s, nstep2_s} != {dir_r, step2_r});
    wrap_nxt_s     = good_s && wrap_det_s;
    if (clr) begin
      locked_nxt_s = 1'b0;
      err_nxt_s    = 1'b0;
      wraps_nxt_s  = '0;
    end else begin
      locked_nxt_s = good_s ? 1'b1 : locked_r;
      err_nxt_s    = bad_s ? 1'b1 : err_r;
      if (wrap_nxt_s && (wraps_r != {WRAP_W{1'b1}})) begin
        wraps_nxt_s = wraps_r + WRAP_W'(1);
      end else begin
        wraps_nxt_s = wraps_r;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_r    <= ST_EMPTY;
      prev_r     <= 4'd0;
      dir_r      <= 1'b0;
      step2_r    <= 1'b0;
      locked_r   <= 1'b0;
      mode_chg_r <= 1'b0;
      wrap_r     <= 1'b0;
      wraps_r    <= '0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      prev_r     <= prev_nxt_s;
      dir_r      <= dir_nxt_s;
      step2_r    <= step2_nxt_s;
      locked_r   <= locked_nxt_s;
      mode_chg_r <= mode_chg_nxt_s;
      wrap_r     <= wrap_nxt_s;
      wraps_r    <= wraps_nxt_s;
      err_r      <= err_nxt_s;
    end
  end

  assign dir      = dir_r;
  assign step2    = step2_r;
  assign locked   = locked_r;
  assign mode_chg = mode_chg_r;
  assign wrap     = wrap_r;
  assign wraps    = wraps_r;
  assign err      = err_r;

`ifdef CNT_STEP_MONITOR_ERRCNT_EN
  logic [ERRC_W-1:0] err_cnt_r;
  logic              err_p_r;

  // Saturating illegal-transition counter and its per-event pulse.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      err_cnt_r <= '0;
      err_p_r   <= 1'b0;
    end else begin
      err_p_r <= bad_s;
      if (clr) begin
        err_cnt_r <= '0;
      end else if (bad_s && (err_cnt_r != {ERRC_W{1'b1}})) begin
        err_cnt_r <= err_cnt_r + ERRC_W'(1);
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end
  end

  assign err_cnt = err_cnt_r;
  assign err_p   = err_p_r;
`endif

endmodule

// File: tb/tb_cnt_step_monitor.sv
// Scoreboard bench for cnt_step_monitor: the driver pushes model predictions,
// an independent monitor pops and compares one entry per clock.
module tb_cnt_step_monitor;
  localparam int WW = 2;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          nrst, en, clr;
  logic [3:0]    cnt;
  logic          dir, step2, locked, mode_chg, wrap, err;
  logic [WW-1:0] wraps;
`ifdef CNT_STEP_MONITOR_ERRCNT_EN
  logic [EW-1:0] err_cnt;
  logic          err_p;
`endif

  always #5 clk = ~clk;

  cnt_step_monitor #(.WRAP_W(WW), .ERRC_W(EW)) dut (
    .clk(clk), .nrst(nrst), .en(en), .clr(clr), .cnt(cnt),
    .dir(dir), .step2(step2), .locked(locked), .mode_chg(mode_chg),
    .wrap(wrap), .wraps(wraps), .err(err)
`ifdef CNT_STEP_MONITOR_ERRCNT_EN
    , .err_cnt(err_cnt), .err_p(err_p)
`endif
  );

  typedef struct {
    int dir, step2, locked, mode_chg, wrap, wraps, err, err_cnt, err_p;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: last sample, whether one exists, decoded mode.
  int m_prev, m_have, m_locked, m_dir, m_step2, m_err, m_wraps, m_errcnt;

  task automatic chk(input string nm, input logic [31:0] act, input int want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, want, $time);
    end
  endtask

  task automatic drive(input bit n, input bit e, input bit c, input int v);
    exp_t x;
    int d, stp, mag, tgt;
    @(negedge clk);
    nrst = n; en = e; clr = c; cnt = v[3:0];
    x.mode_chg = 0; x.wrap = 0; x.err_p = 0;
    if (!n) begin
      m_prev = 0; m_have = 0; m_locked = 0; m_dir = 0; m_step2 = 0;
      m_err = 0; m_wraps = 0; m_errcnt = 0;
    end else if (c) begin
      m_err = 0; m_wraps = 0; m_locked = 0; m_errcnt = 0;
      if (e) m_prev = v;
    end else if (e) begin
      if (m_have == 0) begin
        m_have = 1;
      end else begin
        d   = (v - m_prev + 16) % 16;
        stp = (d < 8) ? d : d - 16;
        mag = (stp < 0) ? -stp : stp;
        if (mag == 1 || mag == 2) begin
          if (m_locked != 0 && ((stp < 0) != (m_dir != 0) || (mag == 2) != (m_step2 != 0)))
            x.mode_chg = 1;
          m_dir = (stp < 0) ? 1 : 0;
          m_step2 = (mag == 2) ? 1 : 0;
          m_locked = 1;
          tgt = m_prev + stp;
          if (tgt < 0 || tgt > 15) begin
            x.wrap = 1;
            if (m_wraps < (1 << WW) - 1) m_wraps++;
          end
        end else begin
          m_err = 1;
          x.err_p = 1;
          if (m_errcnt < (1 << EW) - 1) m_errcnt++;
        end
      end
      m_prev = v;
    end
    x.dir = m_dir; x.step2 = m_step2; x.locked = m_locked; x.wraps = m_wraps;
    x.err = m_err; x.err_cnt = m_errcnt;
    q.push_back(x);
  endtask

  task automatic run_seq(input int vals[]);
    foreach (vals[i]) drive(1'b1, 1'b1, 1'b0, vals[i]);
  endtask

  // Monitor: outputs are valid every cycle, one cycle after the pushing edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("dir", 32'(dir), x.dir);
        chk("step2", 32'(step2), x.step2);
        chk("locked", 32'(locked), x.locked);
        chk("mode_chg", 32'(mode_chg), x.mode_chg);
        chk("wrap", 32'(wrap), x.wrap);
        chk("wraps", 32'(wraps), x.wraps);
        chk("err", 32'(err), x.err);
`ifdef CNT_STEP_MONITOR_ERRCNT_EN
        chk("err_cnt", 32'(err_cnt), x.err_cnt);
        chk("err_p", 32'(err_p), x.err_p);
`endif
      end
    end
  end

  initial begin
    int c, r, s;
    nrst = 1'b0; en = 1'b0; clr = 1'b0; cnt = 4'd0;
    drive(1'b0, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b0, 0);
    run_seq('{0, 1, 2, 3});
    run_seq('{12, 14, 0, 2});
    run_seq('{5, 6, 7, 5, 3});
    run_seq('{1, 0, 15, 14});
    run_seq('{4, 5, 9, 10});
    drive(1'b1, 1'b1, 1'b1, 11);
    drive(1'b1, 1'b0, 1'b0, 11);
    run_seq('{12, 13});
    // Long up1 run through 15/0 for wrap saturation, with en=0 and reset mid-way.
    drive(1'b0, 1'b0, 1'b0, 0);
    c = 10;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, (i % 13) != 7, 1'b0, c);
      if ((i % 13) != 7) c = (c + 1) % 16;
    end
    for (int i = 0; i < 6; i++) begin
      drive(i != 2, 1'b1, 1'b0, c);
      c = (c + 1) % 16;
    end
    // Randomized traffic.
    c = 0;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 88) begin
        s = $urandom_range(0, 3);
        c = (c + ((s == 0) ? 1 : (s == 1) ? 2 : (s == 2) ? 15 : 14)) % 16;
      end else begin
        c = $urandom_range(0, 15);
      end
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 49) == 0, c);
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
